// File: rtl/irq_aggr_ctrl.sv
// Interrupt aggregator: synchronises and conditions peripheral IRQ lines, keeps pending state
// and presents a registered, prioritised IRQ vector to the core over a small register window.
module irq_aggr_ctrl #(
   parameter int NUM_SRC     = 32,
   parameter int SYNC_STAGES = 2,
   parameter int ADDR_W      = 5
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NUM_SRC-1:0] src_i,
   input  logic               mem_valid_i,
   output logic               mem_ready_o,
   input  logic [ADDR_W-1:0]  mem_addr_i,
   input  logic [31:0]        mem_wdata_i,
   input  logic [3:0]         mem_wstrb_i,
   output logic [31:0]        mem_rdata_o,
   output logic [NUM_SRC-1:0] irq_o,
   output logic               irq_any_o,
   output logic [5:0]         irq_id_o
);

   localparam logic [ADDR_W-1:0] ADDR_ENABLE   = ADDR_W'(8'h00);
   localparam logic [ADDR_W-1:0] ADDR_MODE     = ADDR_W'(8'h04);
   localparam logic [ADDR_W-1:0] ADDR_POLARITY = ADDR_W'(8'h08);
   localparam logic [ADDR_W-1:0] ADDR_PENDING  = ADDR_W'(8'h0C);
   localparam logic [ADDR_W-1:0] ADDR_RAW      = ADDR_W'(8'h10);
   localparam logic [ADDR_W-1:0] ADDR_CLAIM    = ADDR_W'(8'h14);

   // Lowest set index plus one; zero when the vector is empty.
   function automatic logic [5:0] lowest_id(input logic [NUM_SRC-1:0] vec);
      logic [5:0] id;
      id = 6'd0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (vec[i]) begin
            id = 6'(i + 1);
         end else begin
            id = id;
         end
      end
      return id;
   endfunction

   function automatic logic [31:0] strb_mask(input logic [3:0] strb);
      return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
   endfunction

   logic [NUM_SRC-1:0] sync_s;
   logic [NUM_SRC-1:0] p_s;
   logic [NUM_SRC-1:0] p_q_r;
   logic [NUM_SRC-1:0] enable_r;
   logic [NUM_SRC-1:0] mode_r;
   logic [NUM_SRC-1:0] polarity_r;
   logic [NUM_SRC-1:0] edge_pend_r;
   logic [NUM_SRC-1:0] enable_nxt_s;
   logic [NUM_SRC-1:0] mode_nxt_s;
   logic [NUM_SRC-1:0] polarity_nxt_s;
   logic [NUM_SRC-1:0] w1c_s;
   logic [NUM_SRC-1:0] claim_clr_s;
   logic [NUM_SRC-1:0] set_s;
   logic [NUM_SRC-1:0] clr_s;
   logic [NUM_SRC-1:0] edge_pend_nxt_s;
   logic [NUM_SRC-1:0] pending_s;
   logic [NUM_SRC-1:0] active_s;
   logic [NUM_SRC-1:0] wmask_n_s;
   logic [NUM_SRC-1:0] wdata_n_s;
   logic [NUM_SRC-1:0] irq_r;
   logic               irq_any_r;
   logic [5:0]         irq_id_r;
   logic               mem_ready_r;
   logic [31:0]        mem_rdata_r;
   logic [31:0]        rdata_nxt_s;
   logic [31:0]        wmask_s;
   logic [ADDR_W-1:0]  word_addr_s;
   logic               accept_s;
   logic               wr_s;
   logic               rd_s;
   logic               claim_hit_s;
   logic               unused_s;

   generate
      if (SYNC_STAGES == 0) begin : g_no_sync
         assign sync_s = src_i;
      end else begin : g_sync
         logic [NUM_SRC-1:0] sync_r [SYNC_STAGES];

         // Metastability chain bringing asynchronous sources into clk_i.
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               for (int k = 0; k < SYNC_STAGES; k++) begin
                  sync_r[k] <= {NUM_SRC{1'b0}};
               end
            end else begin
               sync_r[0] <= src_i;
               for (int k = 1; k < SYNC_STAGES; k++) begin
                  sync_r[k] <= sync_r[k-1];
               end
            end
         end

         assign sync_s = sync_r[SYNC_STAGES-1];
      end
   endgenerate

   assign p_s = sync_s ^ polarity_r;

   // A new request is only taken while no response is being issued, so ready never repeats.
   assign accept_s    = mem_valid_i & ~mem_ready_r;
   assign wr_s        = accept_s & (mem_wstrb_i != 4'h0);
   assign rd_s        = accept_s & (mem_wstrb_i == 4'h0);
   assign word_addr_s = {mem_addr_i[ADDR_W-1:2], 2'b00};
   assign wmask_s     = strb_mask(mem_wstrb_i);
   assign wmask_n_s   = wmask_s[NUM_SRC-1:0];
   assign wdata_n_s   = mem_wdata_i[NUM_SRC-1:0];
   assign claim_hit_s = rd_s & (word_addr_s == ADDR_CLAIM) & (irq_id_r != 6'd0);
   assign unused_s    = ^{mem_addr_i[1:0], mem_wdata_i, wmask_s};

   // Byte-masked register writes and write-1-to-clear decode.
   always_comb begin
      enable_nxt_s   = enable_r;
      mode_nxt_s     = mode_r;
      polarity_nxt_s = polarity_r;
      w1c_s          = {NUM_SRC{1'b0}};
      if (wr_s) begin
         case (word_addr_s)
            ADDR_ENABLE:   enable_nxt_s   = (enable_r & ~wmask_n_s) | (wdata_n_s & wmask_n_s);
            ADDR_MODE:     mode_nxt_s     = (mode_r & ~wmask_n_s) | (wdata_n_s & wmask_n_s);
            ADDR_POLARITY: polarity_nxt_s = (polarity_r & ~wmask_n_s) | (wdata_n_s & wmask_n_s);
            ADDR_PENDING:  w1c_s          = wdata_n_s & wmask_n_s;
            default:       w1c_s          = {NUM_SRC{1'b0}};
         endcase
      end else begin
         w1c_s = {NUM_SRC{1'b0}};
      end
   end

   // Claim clears the source the core currently sees as highest priority.
   always_comb begin
      claim_clr_s = {NUM_SRC{1'b0}};
      for (int i = 0; i < NUM_SRC; i++) begin
         claim_clr_s[i] = claim_hit_s & (irq_id_r == 6'(i + 1));
      end
   end

   // Edge pending: set beats clear; level-mode bits hold nothing, so leaving edge mode discards the latch.
   always_comb begin
      set_s           = p_s & ~p_q_r & mode_r;
      clr_s           = w1c_s | claim_clr_s;
      edge_pend_nxt_s = (set_s | (edge_pend_r & ~clr_s)) & mode_r;
      pending_s       = (mode_r & edge_pend_r) | (~mode_r & p_s);
      active_s        = pending_s & enable_r;
   end

   // Read data multiplexer for the accepted request.
   always_comb begin
      rdata_nxt_s = 32'h0000_0000;
      if (rd_s) begin
         case (word_addr_s)
            ADDR_ENABLE:   rdata_nxt_s = 32'(enable_r);
            ADDR_MODE:     rdata_nxt_s = 32'(mode_r);
            ADDR_POLARITY: rdata_nxt_s = 32'(polarity_r);
            ADDR_PENDING:  rdata_nxt_s = 32'(pending_s);
            ADDR_RAW:      rdata_nxt_s = 32'(p_s);
            ADDR_CLAIM:    rdata_nxt_s = 32'(irq_id_r);
            default:       rdata_nxt_s = 32'h0000_0000;
         endcase
      end else begin
         rdata_nxt_s = 32'h0000_0000;
      end
   end

   // Configuration registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         enable_r   <= {NUM_SRC{1'b0}};
         mode_r     <= {NUM_SRC{1'b0}};
         polarity_r <= {NUM_SRC{1'b0}};
      end else begin
         enable_r   <= enable_nxt_s;
         mode_r     <= mode_nxt_s;
         polarity_r <= polarity_nxt_s;
      end
   end

   // Edge detector history and sticky pending state.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         p_q_r       <= {NUM_SRC{1'b0}};
         edge_pend_r <= {NUM_SRC{1'b0}};
      end else begin
         p_q_r       <= p_s;
         edge_pend_r <= edge_pend_nxt_s;
      end
   end

   // Registered IRQ outputs towards the core.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         irq_r     <= {NUM_SRC{1'b0}};
         irq_any_r <= 1'b0;
         irq_id_r  <= 6'd0;
      end else begin
         irq_r     <= active_s;
         irq_any_r <= |active_s;
         irq_id_r  <= lowest_id(active_s);
      end
   end

   // Single-cycle bus response.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_ready_r <= 1'b0;
         mem_rdata_r <= 32'h0000_0000;
      end else begin
         mem_ready_r <= accept_s;
         mem_rdata_r <= rdata_nxt_s;
      end
   end

   assign mem_ready_o = mem_ready_r;
   assign mem_rdata_o = mem_rdata_r;
   assign irq_o       = irq_r;
   assign irq_any_o   = irq_any_r;
   assign irq_id_o    = irq_id_r;

endmodule

// File: tb/tb_irq_aggr_ctrl.sv
// Bench for irq_aggr_ctrl: register table, directed multi-cycle corner cases and a randomized
// run against a cycle-level reference model of the aggregator rules.
module tb_irq_aggr_ctrl;

   localparam int SYNC = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] src;
   logic        valid;
   logic [4:0]  addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        ready, ready12;
   logic [31:0] rdata, rdata12;
   logic [31:0] irq;
   logic [11:0] irq12;
   logic        any, any12;
   logic [5:0]  id, id12;
   logic [31:0] r, r12;

   int pass_cnt  = 0;
   int total_cnt = 0;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] exp;
      logic [31:0] exp12;
   } vec_t;
   vec_t vecs[$];

   // reference model state
   logic [31:0] m_hist [0:SYNC];
   logic [31:0] m_en, m_mode, m_pol, m_ep, m_pprev, m_rdata, m_irq;
   logic        m_ready;
   logic [5:0]  m_id;

   always #5 clk = ~clk;

   irq_aggr_ctrl #(.NUM_SRC(32), .SYNC_STAGES(SYNC), .ADDR_W(5)) u_dut (
      .clk_i(clk), .rst_i(rst), .src_i(src), .mem_valid_i(valid), .mem_ready_o(ready),
      .mem_addr_i(addr), .mem_wdata_i(wdata), .mem_wstrb_i(wstrb), .mem_rdata_o(rdata),
      .irq_o(irq), .irq_any_o(any), .irq_id_o(id));

   irq_aggr_ctrl #(.NUM_SRC(12), .SYNC_STAGES(SYNC), .ADDR_W(5)) u_dut12 (
      .clk_i(clk), .rst_i(rst), .src_i(src[11:0]), .mem_valid_i(valid), .mem_ready_o(ready12),
      .mem_addr_i(addr), .mem_wdata_i(wdata), .mem_wstrb_i(wstrb), .mem_rdata_o(rdata12),
      .irq_o(irq12), .irq_any_o(any12), .irq_id_o(id12));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; valid = 1'b0; wstrb = 4'h0; src = 32'h0; addr = 5'h0; wdata = 32'h0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic bus_access(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [31:0] rd, output logic [31:0] rd12);
      valid = 1'b1; addr = a; wdata = d; wstrb = s;
      check("ready_idle_before_req", 32'(ready), 32'h0);
      step();
      check("ready_pulse", 32'(ready), 32'h1);
      check("ready_pulse12", 32'(ready12), 32'h1);
      rd = rdata; rd12 = rdata12;
      valid = 1'b0; wstrb = 4'h0;
      step();
      check("ready_single_cycle", 32'(ready), 32'h0);
   endtask

   task automatic model_init();
      for (int j = 0; j <= SYNC; j++) m_hist[j] = 32'h0;
      m_en = 32'h0; m_mode = 32'h0; m_pol = 32'h0; m_ep = 32'h0; m_pprev = 32'h0;
      m_ready = 1'b0; m_rdata = 32'h0; m_irq = 32'h0; m_id = 6'd0;
   endtask

   // One clock edge of the aggregator rules, applied to the inputs present before the edge.
   task automatic model_edge(input logic [31:0] sv, input logic v, input logic [4:0] a,
                             input logic [31:0] wd, input logic [3:0] ws);
      logic [31:0] s, p, pend, act, bm, clr, nep, en_n, mode_n, pol_n;
      logic        acc;
      for (int j = SYNC; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = sv;
      s = m_hist[SYNC];
      p = s ^ m_pol;
      for (int i = 0; i < 32; i++) pend[i] = m_mode[i] ? m_ep[i] : p[i];
      act = pend & m_en;
      acc = v && !m_ready;
      bm = 32'h0;
      for (int b = 0; b < 4; b++) if (ws[b]) bm = bm | (32'hFF << (8 * b));
      clr = 32'h0; en_n = m_en; mode_n = m_mode; pol_n = m_pol; m_rdata = 32'h0;
      if (acc && ws == 4'h0) begin
         case (a[4:2])
            3'd0: m_rdata = m_en;
            3'd1: m_rdata = m_mode;
            3'd2: m_rdata = m_pol;
            3'd3: m_rdata = pend;
            3'd4: m_rdata = p;
            3'd5: begin
               m_rdata = 32'(m_id);
               if (m_id != 6'd0) clr[m_id - 6'd1] = 1'b1;
            end
            default: m_rdata = 32'h0;
         endcase
      end else if (acc) begin
         case (a[4:2])
            3'd0: en_n   = (m_en & ~bm) | (wd & bm);
            3'd1: mode_n = (m_mode & ~bm) | (wd & bm);
            3'd2: pol_n  = (m_pol & ~bm) | (wd & bm);
            3'd3: clr    = wd & bm;
            default: clr = 32'h0;
         endcase
      end
      for (int i = 0; i < 32; i++) begin
         if (!m_mode[i])                nep[i] = 1'b0;
         else if (p[i] && !m_pprev[i])  nep[i] = 1'b1;
         else if (clr[i])               nep[i] = 1'b0;
         else                           nep[i] = m_ep[i];
      end
      m_ep = nep; m_pprev = p; m_en = en_n; m_mode = mode_n; m_pol = pol_n;
      m_ready = acc; m_irq = act;
      m_id = 6'd0;
      for (int i = 0; i < 32; i++) if (act[i] && m_id == 6'd0) m_id = 6'(i + 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected self-termination");
      $fatal(1);
   end

   initial begin
      do_reset();
      check("rst_ready", 32'(ready), 32'h0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_irq", irq, 32'h0);
      check("rst_any", 32'(any), 32'h0);
      check("rst_id", 32'(id), 32'h0);
      check("rst_irq12", 32'(irq12), 32'h0);
      check("rst_any12", 32'(any12), 32'h0);
      check("rst_id12", 32'(id12), 32'h0);

      // register table
      vecs.push_back('{5'h00, 32'h0, 4'h0, 32'h0, 32'h0});
      vecs.push_back('{5'h04, 32'h0, 4'h0, 32'h0, 32'h0});
      vecs.push_back('{5'h08, 32'h0, 4'h0, 32'h0, 32'h0});
      vecs.push_back('{5'h0C, 32'h0, 4'h0, 32'h0, 32'h0});
      vecs.push_back('{5'h10, 32'h0, 4'h0, 32'h0, 32'h0});
      vecs.push_back('{5'h14, 32'h0, 4'h0, 32'h0, 32'h0});
      vecs.push_back('{5'h18, 32'h0, 4'h0, 32'h0, 32'h0});
      vecs.push_back('{5'h1C, 32'h0, 4'h0, 32'h0, 32'h0});
      vecs.push_back('{5'h00, 32'hFFFF_FFFF, 4'b0010, 32'h0, 32'h0});
      vecs.push_back('{5'h00, 32'h0, 4'h0, 32'h0000_FF00, 32'h0000_0F00});
      vecs.push_back('{5'h1C, 32'hFFFF_FFFF, 4'hF, 32'h0, 32'h0});
      vecs.push_back('{5'h1C, 32'h0, 4'h0, 32'h0, 32'h0});
      vecs.push_back('{5'h00, 32'h0, 4'h0, 32'h0000_FF00, 32'h0000_0F00});
      vecs.push_back('{5'h05, 32'h1234_5678, 4'b1001, 32'h0, 32'h0});
      vecs.push_back('{5'h04, 32'h0, 4'h0, 32'h1200_0078, 32'h0000_0078});
      vecs.push_back('{5'h00, 32'hA5A5_A5A5, 4'hF, 32'h0, 32'h0});
      vecs.push_back('{5'h02, 32'h0, 4'h0, 32'hA5A5_A5A5, 32'h0000_05A5});
      vecs.push_back('{5'h08, 32'h0000_FFFF, 4'b1100, 32'h0, 32'h0});
      vecs.push_back('{5'h08, 32'h0, 4'h0, 32'h0, 32'h0});
      vecs.push_back('{5'h04, 32'h0, 4'hF, 32'h0, 32'h0});
      vecs.push_back('{5'h04, 32'h0, 4'h0, 32'h0, 32'h0});
      foreach (vecs[i]) begin
         bus_access(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, r, r12);
         if (vecs[i].wstrb == 4'h0) begin
            check($sformatf("tbl%0d_rdata", i), r, vecs[i].exp);
            check($sformatf("tbl%0d_rdata12", i), r12, vecs[i].exp12);
         end
      end

      // edge latency, sticky pending and W1C
      do_reset();
      bus_access(5'h00, 32'h60, 4'hF, r, r12);
      bus_access(5'h04, 32'h20, 4'hF, r, r12);
      src = 32'h20;
      step();
      src = 32'h0;
      for (int k = 2; k <= SYNC + 1; k++) step();
      check("edge_lat_early", irq, 32'h0);
      step();
      check("edge_lat_irq", irq, 32'h20);
      check("edge_lat_id", 32'(id), 32'd6);
      check("edge_lat_any", 32'(any), 32'h1);
      for (int k = 0; k < 5; k++) step();
      bus_access(5'h0C, 32'h0, 4'h0, r, r12);
      check("edge_sticky", r, 32'h20);
      bus_access(5'h0C, 32'h20, 4'hF, r, r12);
      check("w1c_irq_drop", irq, 32'h0);
      check("w1c_id_drop", 32'(id), 32'h0);
      bus_access(5'h0C, 32'h0, 4'h0, r, r12);
      check("w1c_pending", r, 32'h0);

      // level mode with active-low polarity
      do_reset();
      bus_access(5'h08, 32'h8, 4'hF, r, r12);
      bus_access(5'h00, 32'h8, 4'hF, r, r12);
      check("level_lowact_irq", irq, 32'h8);
      check("level_lowact_id", 32'(id), 32'd4);
      src = 32'h8;
      for (int k = 1; k <= SYNC; k++) step();
      check("level_hold", irq, 32'h8);
      step();
      check("level_drop", irq, 32'h0);
      src = 32'h0;
      for (int k = 0; k < SYNC + 2; k++) step();
      check("level_return", irq, 32'h8);
      bus_access(5'h0C, 32'h8, 4'hF, r, r12);
      check("level_w1c_irq", irq, 32'h8);
      bus_access(5'h0C, 32'h0, 4'h0, r, r12);
      check("level_w1c_pend", r, 32'h8);
      bus_access(5'h10, 32'h0, 4'h0, r, r12);
      check("level_raw", r, 32'h8);

      // claim priority sequence
      do_reset();
      bus_access(5'h00, 32'h204, 4'hF, r, r12);
      bus_access(5'h04, 32'h204, 4'hF, r, r12);
      src = 32'h204;
      step();
      src = 32'h0;
      for (int k = 0; k < 5; k++) step();
      check("claim_id_pre", 32'(id), 32'd3);
      bus_access(5'h14, 32'h0, 4'h0, r, r12);
      check("claim_first", r, 32'd3);
      bus_access(5'h0C, 32'h0, 4'h0, r, r12);
      check("claim_pending", r, 32'h200);
      bus_access(5'h14, 32'h0, 4'h0, r, r12);
      check("claim_second", r, 32'd10);
      bus_access(5'h14, 32'h0, 4'h0, r, r12);
      check("claim_none", r, 32'd0);
      check("claim_none_id", 32'(id), 32'd0);

      // W1C colliding with a new edge on the same bit
      do_reset();
      bus_access(5'h04, 32'h10, 4'hF, r, r12);
      bus_access(5'h00, 32'h10, 4'hF, r, r12);
      src = 32'h10;
      for (int k = 0; k < SYNC; k++) step();
      bus_access(5'h0C, 32'h10, 4'hF, r, r12);
      bus_access(5'h0C, 32'h0, 4'h0, r, r12);
      check("set_wins_pending", r, 32'h10);
      check("set_wins_irq", irq, 32'h10);
      bus_access(5'h0C, 32'h10, 4'hF, r, r12);
      bus_access(5'h0C, 32'h0, 4'h0, r, r12);
      check("w1c_no_edge", r, 32'h0);

      // reset during a pending write drops it
      valid = 1'b1; addr = 5'h00; wdata = 32'hFF; wstrb = 4'hF; rst = 1'b1;
      step();
      check("rst_mid_ready", 32'(ready), 32'h0);
      rst = 1'b0; valid = 1'b0; wstrb = 4'h0;
      step();
      check("rst_mid_ready2", 32'(ready), 32'h0);
      bus_access(5'h00, 32'h0, 4'h0, r, r12);
      check("rst_mid_dropped", r, 32'h0);

      // randomized run against the reference model
      do_reset();
      model_init();
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 3) == 0) src = $urandom;
         valid = ($urandom_range(0, 2) != 0);
         addr  = ($urandom_range(0, 2) == 0) ? 5'h14 : 5'($urandom_range(0, 31));
         wdata = $urandom;
         wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         step();
         model_edge(src, valid, addr, wdata, wstrb);
         check("rnd_ready", 32'(ready), 32'(m_ready));
         check("rnd_irq", irq, m_irq);
         check("rnd_any", 32'(any), 32'(m_irq != 32'h0));
         check("rnd_id", 32'(id), 32'(m_id));
         if (m_ready) check("rnd_rdata", rdata, m_rdata);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
